// File: rtl/pcie_rx_tlp.sv
// pcie_rx_tlp: 64-bit PCIe RX TLP decoder for MWr/MRd/CplD emitting byte-swapped payload qwords
module pcie_rx_tlp #(
  parameter int AW    = 13,
  parameter bit EN_64 = 1'b1,
  parameter int IW    = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          tvalid,
  input  logic          tlast,
  input  logic [63:0]   tdata,
  output logic          write_valid,
  output logic          read_valid,
  output logic          completion_valid,
  output logic [63:0]   data,
  output logic [AW-1:0] address,
  output logic [10:0]   read_len,
  output logic [23:0]   rid_tag,
  output logic [7:0]    cpl_tag,
  output logic [IW-1:0] cpl_index,
  output logic          unsupported
);
  typedef enum logic [1:0] {HDR, ADDR, DATA, DROP} state_t;
  state_t state_q, state_d;
  logic in_v_q, in_v_d, in_last_q, in_last_d;
  logic [63:0] in_d_q, in_d_d;
  logic wr_q, wr_d, rd_q, rd_d, cpl_q, cpl_d, is4_q, is4_d;
  logic [9:0] len_q, len_d, rem_q, rem_d;
  logic [31:0] prev_q, prev_d;
  logic [AW-1:0] addr_q, addr_d, address_q, address_d;
  logic [IW-1:0] idx_q, idx_d, cpl_index_q, cpl_index_d;
  logic write_valid_q, write_valid_d, read_valid_q, read_valid_d;
  logic completion_valid_q, completion_valid_d, unsupported_q, unsupported_d;
  logic [63:0] data_q, data_d;
  logic [10:0] read_len_q, read_len_d;
  logic [23:0] rid_tag_q, rid_tag_d;
  logic [7:0] cpl_tag_q, cpl_tag_d;
  logic [6:0] ft;
  logic h_wr, h_rd, h_cpl, h_bad, misalign;
  logic [AW-1:0] a_hdr;
  logic [63:0] pay;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign ft       = in_d_q[30:24];
  assign h_wr     = ft == 7'b1000000 || ft == 7'b1100000;
  assign h_rd     = ft == 7'b0000000 || ft == 7'b0100000;
  assign h_cpl    = ft == 7'b1001010;
  assign h_bad    = !(h_wr || h_rd || h_cpl) || in_d_q[14] || in_d_q[0] || (in_d_q[29] && !EN_64);
  // 4DW headers carry the low address DW in the upper half of the second beat
  assign a_hdr    = is4_q ? in_d_q[AW+34:35] : in_d_q[AW+2:3];
  assign misalign = (wr_q || rd_q) && (is4_q ? in_d_q[34] : in_d_q[2]);
  // 3DW payload straddles beats: low DW of the qword arrived in the previous beat
  assign pay      = is4_q ? in_d_q : {in_d_q[31:0], prev_q};

  always_comb begin
    in_v_d = tvalid;
    in_last_d = tvalid && tlast;
    in_d_d = tdata;
    state_d = state_q;
    wr_d = wr_q;
    rd_d = rd_q;
    cpl_d = cpl_q;
    is4_d = is4_q;
    len_d = len_q;
    rem_d = rem_q;
    prev_d = prev_q;
    addr_d = addr_q;
    idx_d = idx_q;
    address_d = address_q;
    cpl_index_d = cpl_index_q;
    data_d = data_q;
    read_len_d = read_len_q;
    rid_tag_d = rid_tag_q;
    cpl_tag_d = cpl_tag_q;
    write_valid_d = 1'b0;
    read_valid_d = 1'b0;
    completion_valid_d = 1'b0;
    unsupported_d = 1'b0;
    if (in_v_q) begin
      case (state_q)
        HDR: begin
          wr_d = h_wr;
          rd_d = h_rd;
          cpl_d = h_cpl;
          is4_d = in_d_q[29];
          len_d = in_d_q[9:0];
          rid_tag_d = in_d_q[63:40];
          unsupported_d = in_last_q;
          state_d = in_last_q ? HDR : h_bad ? DROP : ADDR;
        end
        ADDR: begin
          addr_d = a_hdr;
          prev_d = in_d_q[63:32];
          idx_d = '0;
          rem_d = rd_q ? '0 : {len_q == '0, len_q[9:1]};
          cpl_tag_d = cpl_q ? in_d_q[15:8] : cpl_tag_q;
          read_valid_d = rd_q && !misalign;
          address_d = read_valid_d ? a_hdr : address_q;
          read_len_d = read_valid_d ? {len_q == '0, len_q} : read_len_q;
          unsupported_d = in_last_q && (misalign || !rd_q);
          state_d = in_last_q ? HDR : misalign ? DROP : DATA;
        end
        DATA: begin
          write_valid_d = wr_q && rem_q != '0;
          completion_valid_d = cpl_q && rem_q != '0;
          if (rem_q != '0) begin
            data_d = {bswap(pay[63:32]), bswap(pay[31:0])};
            address_d = addr_q;
            cpl_index_d = idx_q;
            addr_d = addr_q + 1'b1;
            idx_d = idx_q + 1'b1;
            rem_d = rem_q - 1'b1;
          end
          prev_d = in_d_q[63:32];
          unsupported_d = in_last_q && rem_q > 10'd1;
          state_d = in_last_q ? HDR : DATA;
        end
        default: begin
          unsupported_d = in_last_q;
          state_d = in_last_q ? HDR : DROP;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HDR;
      in_v_q <= 1'b0;
      in_last_q <= 1'b0;
      in_d_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cpl_q <= 1'b0;
      is4_q <= 1'b0;
      len_q <= '0;
      rem_q <= '0;
      prev_q <= '0;
      addr_q <= '0;
      idx_q <= '0;
      address_q <= '0;
      cpl_index_q <= '0;
      data_q <= '0;
      read_len_q <= '0;
      rid_tag_q <= '0;
      cpl_tag_q <= '0;
      write_valid_q <= 1'b0;
      read_valid_q <= 1'b0;
      completion_valid_q <= 1'b0;
      unsupported_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_v_q <= in_v_d;
      in_last_q <= in_last_d;
      in_d_q <= in_d_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cpl_q <= cpl_d;
      is4_q <= is4_d;
      len_q <= len_d;
      rem_q <= rem_d;
      prev_q <= prev_d;
      addr_q <= addr_d;
      idx_q <= idx_d;
      address_q <= address_d;
      cpl_index_q <= cpl_index_d;
      data_q <= data_d;
      read_len_q <= read_len_d;
      rid_tag_q <= rid_tag_d;
      cpl_tag_q <= cpl_tag_d;
      write_valid_q <= write_valid_d;
      read_valid_q <= read_valid_d;
      completion_valid_q <= completion_valid_d;
      unsupported_q <= unsupported_d;
    end
  end

  assign write_valid      = write_valid_q;
  assign read_valid       = read_valid_q;
  assign completion_valid = completion_valid_q;
  assign data             = data_q;
  assign address          = address_q;
  assign read_len         = read_len_q;
  assign rid_tag          = rid_tag_q;
  assign cpl_tag          = cpl_tag_q;
  assign cpl_index        = cpl_index_q;
  assign unsupported      = unsupported_q;
endmodule

// File: tb/tb_pcie_rx_tlp.sv
// tb_pcie_rx_tlp: directed TLP streams checked against a DW-stream model of the decoder
module tb_pcie_rx_tlp;
  localparam int AW = 13;
  localparam int IW = 7;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tvalid = 1'b0;
  logic tlast = 1'b0;
  logic [63:0] tdata = '0;
  logic write_valid, read_valid, completion_valid, unsupported;
  logic [63:0] data;
  logic [AW-1:0] address;
  logic [10:0] read_len;
  logic [23:0] rid_tag;
  logic [7:0] cpl_tag;
  logic [IW-1:0] cpl_index;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  typedef struct packed {
    logic wv, rv, cv, un;
    logic [63:0] d;
    logic [AW-1:0] a;
    logic [10:0] rl;
    logic [23:0] rid;
    logic [7:0] ct;
    logic [IW-1:0] ci;
  } ev_t;
  ev_t p1 = '0;
  ev_t p2 = '0;

  logic [31:0] dws[$];
  bit m_drop, m_wr, m_rd, m_cpl;
  int m_hs, m_len, m_done;
  logic [AW-1:0] m_base;
  logic [23:0] m_rid;
  logic [7:0] m_tag;

  logic [AW-1:0] wa[$];
  logic [63:0] wd[$];
  int wc[$];
  logic [AW-1:0] ra[$];
  logic [10:0] rl[$];
  logic [23:0] rr[$];
  logic [IW-1:0] ci[$];
  logic [7:0] ct[$];
  logic [63:0] cd[$];
  int n_un = 0;

  always #5 clock = ~clock;

  pcie_rx_tlp dut (
    .clock(clock), .reset(reset), .tvalid(tvalid), .tlast(tlast), .tdata(tdata),
    .write_valid(write_valid), .read_valid(read_valid), .completion_valid(completion_valid),
    .data(data), .address(address), .read_len(read_len), .rid_tag(rid_tag),
    .cpl_tag(cpl_tag), .cpl_index(cpl_index), .unsupported(unsupported)
  );

  function automatic logic [63:0] swp(input logic [63:0] x);
    logic [31:0] hi, lo;
    hi = {<<8{x[63:32]}};
    lo = {<<8{x[31:0]}};
    return {hi, lo};
  endfunction

  function automatic logic [31:0] dw0(input logic [6:0] ft, input logic ep, input logic [9:0] len);
    return {1'b0, ft, 9'b0, ep, 4'b0, len};
  endfunction

  function automatic logic [63:0] pp(input int i);
    return {32'(32'h55000000 + i + 1), 32'(32'h55000000 + i)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: collect the TLP as a DW stream; outputs follow from DW counts two cycles later
  always @(posedge clock) begin : model
    ev_t e;
    int avail;
    logic [31:0] a;
    cyc++;
    e = '0;
    if (reset) begin
      dws.delete();
      p1 = '0;
      p2 = '0;
    end else begin
      if (tvalid) begin
        dws.push_back(tdata[31:0]);
        dws.push_back(tdata[63:32]);
        if (dws.size() == 2) begin
          m_wr = dws[0][30:24] inside {7'h40, 7'h60};
          m_rd = dws[0][30:24] inside {7'h00, 7'h20};
          m_cpl = dws[0][30:24] == 7'h4A;
          m_hs = dws[0][29] ? 4 : 3;
          m_len = (dws[0][9:0] == 10'd0) ? 1024 : int'(dws[0][9:0]);
          m_drop = !(m_wr || m_rd || m_cpl) || dws[0][14] || (m_len % 2 != 0) || (m_hs == 4 && !dut.EN_64);
          m_rid = dws[1][31:8];
          m_done = 0;
        end
        if (dws.size() == 4 && !m_drop) begin
          a = dws[m_hs-1];
          if ((m_wr || m_rd) && a[2]) m_drop = 1'b1;
          else begin
            m_base = a[AW+2:3];
            m_tag = dws[2][15:8];
            if (m_rd) begin
              e.rv = 1'b1;
              e.a = m_base;
              e.rl = 11'(m_len);
              e.rid = m_rid;
            end
          end
        end
        if (dws.size() >= 4 && !m_drop && !m_rd) begin
          avail = (dws.size() - m_hs) / 2;
          if (avail > m_len / 2) avail = m_len / 2;
          while (m_done < avail) begin
            e.wv = m_wr;
            e.cv = m_cpl;
            e.d = swp({dws[m_hs+2*m_done+1], dws[m_hs+2*m_done]});
            e.a = m_base + AW'(m_done);
            e.ci = IW'(m_done);
            e.ct = m_tag;
            e.rid = m_rid;
            m_done++;
          end
        end
        if (tlast) begin
          e.un = m_drop || dws.size() == 2 || ((m_wr || m_cpl) && m_done < m_len / 2);
          dws.delete();
        end
      end
      p2 = p1;
      p1 = e;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("valids", 64'({write_valid, read_valid, completion_valid, unsupported}), 64'({p2.wv, p2.rv, p2.cv, p2.un}));
      if (p2.wv) begin
        check("wr_data", data, p2.d);
        check("wr_addr", 64'(address), 64'(p2.a));
        check("wr_rid", 64'(rid_tag), 64'(p2.rid));
      end
      if (p2.rv) begin
        check("rd_addr", 64'(address), 64'(p2.a));
        check("rd_len", 64'(read_len), 64'(p2.rl));
        check("rd_rid", 64'(rid_tag), 64'(p2.rid));
      end
      if (p2.cv) begin
        check("cpl_data", data, p2.d);
        check("cpl_tag", 64'(cpl_tag), 64'(p2.ct));
        check("cpl_idx", 64'(cpl_index), 64'(p2.ci));
      end
      if (write_valid) begin
        wa.push_back(address);
        wd.push_back(data);
        wc.push_back(cyc);
      end
      if (read_valid) begin
        ra.push_back(address);
        rl.push_back(read_len);
        rr.push_back(rid_tag);
      end
      if (completion_valid) begin
        ci.push_back(cpl_index);
        ct.push_back(cpl_tag);
        cd.push_back(data);
      end
      if (unsupported) n_un++;
    end
  end

  task automatic beat(input logic [63:0] d, input bit l);
    @(negedge clock);
    tvalid = 1'b1;
    tdata = d;
    tlast = l;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      tvalid = 1'b0;
      tlast = 1'b0;
      tdata = '0;
    end
  endtask

  task automatic clr();
    wa.delete(); wd.delete(); wc.delete();
    ra.delete(); rl.delete(); rr.delete();
    ci.delete(); ct.delete(); cd.delete();
    n_un = 0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_valids", 64'({write_valid, read_valid, completion_valid, unsupported}), 64'd0);
    check("rst_data", data, 64'd0);
    check("rst_fields", 64'({address, read_len, rid_tag, cpl_tag, cpl_index}), 64'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    beat({32'h123456FF, dw0(7'h40, 1'b0, 10'd2)}, 1'b0);
    beat({32'h11223344, 32'h00001008}, 1'b0);
    beat({32'h00000000, 32'h55667788}, 1'b1);
    idle(4);
    check("t1_nwr", 64'(wa.size()), 64'd1);
    if (wa.size() == 1) begin
      check("t1_addr", 64'(wa[0]), 64'h201);
      check("t1_data", wd[0], 64'h8877665544332211);
    end
    clr();

    beat({32'h000001FF, dw0(7'h60, 1'b0, 10'd8)}, 1'b0);
    beat({32'h0000FFF8, 32'h00000000}, 1'b0);
    beat(64'h0102030405060708, 1'b0);
    beat(64'h1112131415161718, 1'b0);
    beat(64'h2122232425262728, 1'b0);
    beat(64'h3132333435363738, 1'b1);
    idle(4);
    check("t2_nwr", 64'(wa.size()), 64'd4);
    if (wa.size() == 4) begin
      check("t2_a0", 64'(wa[0]), 64'h1FFF);
      check("t2_a1", 64'(wa[1]), 64'h0000);
      check("t2_a2", 64'(wa[2]), 64'h0001);
      check("t2_a3", 64'(wa[3]), 64'h0002);
      check("t2_d0", wd[0], 64'h0403020108070605);
      check("t2_back2back", 64'(wc[3] - wc[0]), 64'd3);
    end
    clr();

    beat({32'hABCD120F, dw0(7'h00, 1'b0, 10'd0)}, 1'b0);
    beat({32'h00000000, 32'h00000040}, 1'b1);
    idle(4);
    check("t3_nwr", 64'(wa.size()), 64'd0);
    check("t3_nrd", 64'(ra.size()), 64'd1);
    if (ra.size() == 1) begin
      check("t3_addr", 64'(ra[0]), 64'h8);
      check("t3_len", 64'(rl[0]), 64'd1024);
      check("t3_rid", 64'(rr[0]), 64'hABCD12);
    end
    clr();

    beat({32'h01000000, dw0(7'h4A, 1'b0, 10'd6)}, 1'b0);
    beat({32'hAABBCCDD, 32'h00005A00}, 1'b0);
    beat({32'h44556677, 32'h00112233}, 1'b0);
    beat({32'h8899AABB, 32'hCCDDEEFF}, 1'b0);
    beat({32'h00000000, 32'h13572468}, 1'b1);
    beat({32'h01000000, dw0(7'h4A, 1'b0, 10'd2)}, 1'b0);
    beat({32'hCAFEF00D, 32'h00007700}, 1'b0);
    beat({32'h00000000, 32'hDEADBEEF}, 1'b1);
    idle(4);
    check("t4_ncpl", 64'(ci.size()), 64'd4);
    if (ci.size() == 4) begin
      check("t4_i0", 64'(ci[0]), 64'd0);
      check("t4_i1", 64'(ci[1]), 64'd1);
      check("t4_i2", 64'(ci[2]), 64'd2);
      check("t4_i3", 64'(ci[3]), 64'd0);
      check("t4_tag0", 64'(ct[0]), 64'h5A);
      check("t4_tag2", 64'(ct[2]), 64'h5A);
      check("t4_tag3", 64'(ct[3]), 64'h77);
      check("t4_d0", cd[0], 64'h33221100DDCCBBAA);
    end
    check("t4_nun", 64'(n_un), 64'd0);
    clr();

    beat({32'h00000000, dw0(7'h40, 1'b0, 10'd4)}, 1'b0);
    beat({32'h12345678, 32'h00000100}, 1'b1);
    beat({32'h00000001, dw0(7'h00, 1'b1, 10'd2)}, 1'b0);
    beat({32'h00000000, 32'h00000080}, 1'b1);
    beat({32'h00000002, dw0(7'h40, 1'b0, 10'd2)}, 1'b0);
    beat({32'h11111111, 32'h00000104}, 1'b0);
    beat({32'h00000000, 32'h22222222}, 1'b1);
    beat({32'h00000003, dw0(7'h00, 1'b0, 10'd1)}, 1'b0);
    beat({32'h00000000, 32'h00000090}, 1'b1);
    beat({32'h55667701, dw0(7'h00, 1'b0, 10'd2)}, 1'b0);
    beat({32'h00000000, 32'h00000088}, 1'b1);
    idle(4);
    check("t5_nwr", 64'(wa.size()), 64'd0);
    check("t5_nun", 64'(n_un), 64'd4);
    check("t5_nrd", 64'(ra.size()), 64'd1);
    if (ra.size() == 1) begin
      check("t5_addr", 64'(ra[0]), 64'h11);
      check("t5_len", 64'(rl[0]), 64'd2);
      check("t5_rid", 64'(rr[0]), 64'h556677);
    end
    clr();

    beat({32'h00AA0000, dw0(7'h40, 1'b0, 10'd16)}, 1'b0);
    beat({pp(0)[31:0], 32'h00002000}, 1'b0);
    beat(pp(1), 1'b0);
    idle(2);
    beat(pp(3), 1'b0);
    beat(pp(5), 1'b0);
    @(negedge clock);
    reset = 1'b1;
    tvalid = 1'b1;
    tdata = pp(7);
    tlast = 1'b0;
    @(negedge clock);
    check("t6_post_rst", 64'({write_valid, read_valid, completion_valid, unsupported}), 64'd0);
    check("t6_nwr", 64'(wa.size()), 64'd2);
    if (wa.size() == 2) begin
      check("t6_a0", 64'(wa[0]), 64'h400);
      check("t6_a1", 64'(wa[1]), 64'h401);
      check("t6_gap", 64'(wc[1] - wc[0]), 64'd3);
    end
    clr();
    reset = 1'b0;
    tvalid = 1'b1;
    tdata = pp(9);
    tlast = 1'b0;
    beat(pp(11), 1'b0);
    beat(pp(13), 1'b1);
    beat({32'h00BB0000, dw0(7'h40, 1'b0, 10'd2)}, 1'b0);
    beat({32'h01020304, 32'h00003010}, 1'b0);
    beat({32'h00000000, 32'h05060708}, 1'b1);
    idle(4);
    check("t6_nun", 64'(n_un), 64'd1);
    check("t6_nwr2", 64'(wa.size()), 64'd1);
    if (wa.size() == 1) begin
      check("t6_addr2", 64'(wa[0]), 64'h602);
      check("t6_data2", wd[0], 64'h0807060504030201);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
